// File: rtl/net_pkg.sv
// Shared definitions for the 2-3 neuron net and its parameter loader:
// loader FSM states, frame constants and parameter slot indices.
package net_pkg;

  localparam int unsigned NET_DATA_W  = 8;
  localparam int unsigned NET_N_PARAM = 9;
  localparam logic [7:0]  NET_HDR     = 8'hA5;

  // Slot order of the payload, identical to the order on the wire.
  localparam int unsigned IDX_W1 = 0;
  localparam int unsigned IDX_W2 = 1;
  localparam int unsigned IDX_W3 = 2;
  localparam int unsigned IDX_W4 = 3;
  localparam int unsigned IDX_W5 = 4;
  localparam int unsigned IDX_W6 = 5;
  localparam int unsigned IDX_B1 = 6;
  localparam int unsigned IDX_B2 = 7;
  localparam int unsigned IDX_B3 = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAYLOAD,
    ST_CHECK,
    ST_COMMIT
  } net_state_e;

endpackage

// File: rtl/param_gap_timer.sv
// Inter-byte gap timer for the parameter loader. Counts idle cycles and
// flags the cycle whose closing edge would bring the count to TIMEOUT-1.
module param_gap_timer #(
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic clk,
  input  logic reset_p,
  input  logic clear_i,
  input  logic count_i,
  output logic expired_o
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT - 2);

  logic [15:0] cnt_q;

  // Gap counter: cleared on demand, otherwise advances while counting is enabled.
  always_ff @(posedge clk) begin
    if (reset_p || clear_i) begin
      cnt_q <= '0;
    end else if (count_i) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  // Fires on the edge at which the count would reach TIMEOUT-1; the owner
  // clears the counter on that same edge, so it never wraps.
  assign expired_o = count_i && (cnt_q == LIMIT);

endmodule

// File: rtl/net_param_loader.sv
// Byte-stream loader for the net's weights and biases. A frame is a header,
// nine payload bytes and an XOR checksum; all nine values are committed to
// the active bank together so the net never sees a mixed parameter set.
module net_param_loader
  import net_pkg::*;
#(
  parameter int unsigned DATA_W  = NET_DATA_W,
  parameter int unsigned N_PARAM = NET_N_PARAM,
  parameter logic [DATA_W-1:0] HDR = NET_HDR,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic                     clk,
  input  logic                     reset_p,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [DATA_W-1:0] w1,
  output logic signed [DATA_W-1:0] w2,
  output logic signed [DATA_W-1:0] w3,
  output logic signed [DATA_W-1:0] w4,
  output logic signed [DATA_W-1:0] w5,
  output logic signed [DATA_W-1:0] w6,
  output logic signed [DATA_W-1:0] bias1,
  output logic signed [DATA_W-1:0] bias2,
  output logic signed [DATA_W-1:0] bias3,
  output logic                     params_valid,
  output logic                     commit_pulse,
  output logic                     err_checksum,
  output logic                     err_timeout,
  output logic                     busy
);

  localparam int unsigned IDX_BITS = $clog2(N_PARAM);
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(N_PARAM - 1);

  net_state_e          state_q;
  logic [IDX_BITS-1:0] idx_q;
  logic [DATA_W-1:0]   xor_q;
  logic [DATA_W-1:0]   shadow_q [N_PARAM];
  logic [DATA_W-1:0]   active_q [N_PARAM];
  logic                pvalid_q;
  logic                commit_q;
  logic                errc_q;
  logic                errt_q;

  logic accept;
  logic in_frame;
  logic gap_expired;

  assign in_ready = (state_q != ST_COMMIT);
  assign busy     = (state_q != ST_IDLE);
  assign accept   = in_valid && in_ready;
  assign in_frame = (state_q == ST_PAYLOAD) || (state_q == ST_CHECK);

  // An accepted byte in the expiry cycle suppresses the timeout because
  // counting is disabled whenever a byte transfers.
  param_gap_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_gap_timer (
    .clk      (clk),
    .reset_p  (reset_p),
    .clear_i  (!in_frame || accept || gap_expired),
    .count_i  (in_frame && !accept),
    .expired_o(gap_expired)
  );

  // Frame FSM with shadow/active banks and registered status pulses.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      xor_q    <= '0;
      pvalid_q <= 1'b0;
      commit_q <= 1'b0;
      errc_q   <= 1'b0;
      errt_q   <= 1'b0;
      for (int unsigned i = 0; i < N_PARAM; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      commit_q <= 1'b0;
      errc_q   <= 1'b0;
      errt_q   <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (accept && (in_data == HDR)) begin
            state_q <= ST_PAYLOAD;
            idx_q   <= '0;
            xor_q   <= '0;
          end
        end
        ST_PAYLOAD: begin
          if (accept) begin
            shadow_q[idx_q] <= in_data;
            xor_q           <= xor_q ^ in_data;
            idx_q           <= idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
              state_q <= ST_CHECK;
            end
          end else if (gap_expired) begin
            errt_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        ST_CHECK: begin
          if (accept) begin
            if (in_data == xor_q) begin
              state_q <= ST_COMMIT;
            end else begin
              errc_q  <= 1'b1;
              state_q <= ST_IDLE;
            end
          end else if (gap_expired) begin
            errt_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        ST_COMMIT: begin
          active_q <= shadow_q;
          pvalid_q <= 1'b1;
          commit_q <= 1'b1;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign w1    = active_q[IDX_W1];
  assign w2    = active_q[IDX_W2];
  assign w3    = active_q[IDX_W3];
  assign w4    = active_q[IDX_W4];
  assign w5    = active_q[IDX_W5];
  assign w6    = active_q[IDX_W6];
  assign bias1 = active_q[IDX_B1];
  assign bias2 = active_q[IDX_B2];
  assign bias3 = active_q[IDX_B3];

  assign params_valid = pvalid_q;
  assign commit_pulse = commit_q;
  assign err_checksum = errc_q;
  assign err_timeout  = errt_q;

endmodule
